// File: rtl/dcpu_pkg.sv
// Shared definitions for the DCPU run controller: ISA opcodes, host command codes, FSM states.
package dcpu_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_ST   = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_XOR  = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_SHR  = 5'b01010;
  localparam logic [4:0] OP_CMP  = 5'b01011;
  localparam logic [4:0] OP_JMP  = 5'b01100;
  localparam logic [4:0] OP_JZ   = 5'b01101;
  localparam logic [4:0] OP_JNZ  = 5'b01110;
  localparam logic [4:0] OP_LDI  = 5'b10111;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_CRST  = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4,
    ST_PAUSE = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAULT = 3'd7
  } state_e;

endpackage

// File: rtl/dcpu_cycle_counter.sv
// Saturating count of core-enabled cycles with watchdog compare against TIMEOUT.
module dcpu_cycle_counter #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count,
  output logic        at_limit,
  output logic        reach_limit
);

  logic [15:0] count_q, count_d;
  logic        not_sat;

  assign not_sat = (count_q != 16'hFFFF);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 16'h0000;
    end else if (en && not_sat) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign at_limit    = (count_q == TIMEOUT);
  // Lets the FSM leave RUN on the same edge the count lands on TIMEOUT.
  assign reach_limit = en && not_sat && ((count_q + 16'd1) == TIMEOUT);

endmodule

// File: rtl/dcpu_run_ctrl.sv
// Host-side run controller: loads instruction memory and sequences DCPU reset/run/step/abort.
//   state | meaning
//   IDLE  | waiting for a host command
//   WRITE | one-cycle instruction memory write
//   CRST  | core held in reset for two cycles
//   RUN   | core free-running under the watchdog
//   STEP  | core enabled for a single cycle
//   PAUSE | core stopped mid-program, resumable
//   DONE  | HALT retired
//   FAULT | watchdog expired
module dcpu_run_ctrl
  import dcpu_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [1:0]  CmdOp,
  input  logic [7:0]  CmdAddr,
  input  logic [15:0] CmdData,
  output logic        IMemWE,
  output logic [7:0]  IMemAddr,
  output logic [15:0] IMemWData,
  input  logic [7:0]  CpuInstMemAddr,
  input  logic [15:0] Inst,
  output logic        CpuRST,
  output logic        CpuEN,
  output logic        CpuStart,
  output logic [2:0]  State,
  output logic [15:0] CycleCount,
  output logic        Done,
  output logic        Fault
);

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic        crst_tail_q, crst_tail_d;
  logic        crst_step_q, crst_step_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        we_q, we_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  cmd_e        cmd_op;
  logic        cmd_ready;
  logic        accept;
  logic        halt;
  logic        inst_unused;
  logic        at_limit;
  logic        reach_limit;
  logic        cnt_clr;

  assign cmd_op      = cmd_e'(CmdOp);
  assign halt        = (Inst[15:11] == OP_HALT);
  assign inst_unused = ^Inst[10:0];

  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_PAUSE, ST_DONE, ST_FAULT: cmd_ready = 1'b1;
      ST_RUN, ST_STEP, ST_CRST:             cmd_ready = (cmd_op == CMD_ABORT);
      default:                              cmd_ready = 1'b0;
    endcase
    if (RST) begin
      cmd_ready = 1'b0;
    end
  end

  assign accept = CmdValid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    crst_tail_d = crst_tail_q;
    crst_step_d = crst_step_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (accept && (cmd_op == CMD_ABORT)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE, ST_DONE, ST_FAULT: begin
          if (accept) begin
            case (cmd_op)
              CMD_WRITE: begin
                state_d   = ST_WRITE;
                ret_d     = state_q;
                wr_addr_d = CmdAddr;
                wr_data_d = CmdData;
              end
              CMD_RUN, CMD_STEP: begin
                // Resuming from PAUSE must not reset the core.
                if (state_q == ST_PAUSE) begin
                  state_d = (cmd_op == CMD_RUN) ? ST_RUN : ST_STEP;
                end else begin
                  state_d     = ST_CRST;
                  crst_tail_d = 1'b0;
                  crst_step_d = (cmd_op == CMD_STEP);
                end
              end
              default: state_d = state_q;
            endcase
          end
        end
        ST_WRITE: state_d = ret_q;
        ST_CRST: begin
          if (crst_tail_q) begin
            state_d = crst_step_q ? ST_STEP : ST_RUN;
          end else begin
            crst_tail_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (halt) begin
            state_d = ST_DONE;
          end else if (at_limit || reach_limit) begin
            state_d = ST_FAULT;
          end
        end
        ST_STEP: state_d = halt ? ST_DONE : ST_PAUSE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    we_d    = (state_d == ST_WRITE);
    en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    done_d  = done_q;
    fault_d = fault_q;
    if (state_d == ST_CRST) begin
      done_d  = 1'b0;
      fault_d = 1'b0;
    end else begin
      if (state_d == ST_DONE)  done_d  = 1'b1;
      if (state_d == ST_FAULT) fault_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      crst_tail_q <= 1'b0;
      crst_step_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 16'h0000;
      we_q        <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      crst_tail_q <= crst_tail_d;
      crst_step_q <= crst_step_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      we_q        <= we_d;
      en_q        <= en_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign cnt_clr = (state_d == ST_CRST);

  dcpu_cycle_counter #(.TIMEOUT(TIMEOUT)) u_cycle_counter (
    .clk         (CLK),
    .rst         (RST),
    .clr         (cnt_clr),
    .en          (en_q),
    .count       (CycleCount),
    .at_limit    (at_limit),
    .reach_limit (reach_limit)
  );

  assign CmdReady  = cmd_ready;
  assign CpuRST    = RST || (state_q == ST_CRST);
  assign CpuEN     = en_q;
  assign CpuStart  = en_q;
  assign IMemWE    = we_q;
  assign IMemAddr  = (state_q == ST_WRITE) ? wr_addr_q : CpuInstMemAddr;
  assign IMemWData = wr_data_q;
  assign State     = state_q;
  assign Done      = done_q;
  assign Fault     = fault_q;

endmodule

// File: tb/tb_dcpu_run_ctrl.sv
// Bench for dcpu_run_ctrl: behavioural instruction memory and core PC, write/termination scoreboards.
module tb_dcpu_run_ctrl;
  import dcpu_pkg::*;

  localparam logic [15:0] TMO = 16'd8;

  logic        CLK, RST;
  logic        CmdValid, CmdReady;
  logic [1:0]  CmdOp;
  logic [7:0]  CmdAddr;
  logic [15:0] CmdData;
  logic        IMemWE;
  logic [7:0]  IMemAddr;
  logic [15:0] IMemWData;
  logic [7:0]  CpuInstMemAddr;
  logic [15:0] Inst;
  logic        CpuRST, CpuEN, CpuStart;
  logic [2:0]  State;
  logic [15:0] CycleCount;
  logic        Done, Fault;

  dcpu_run_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
    .CmdAddr(CmdAddr), .CmdData(CmdData), .IMemWE(IMemWE), .IMemAddr(IMemAddr),
    .IMemWData(IMemWData), .CpuInstMemAddr(CpuInstMemAddr), .Inst(Inst),
    .CpuRST(CpuRST), .CpuEN(CpuEN), .CpuStart(CpuStart), .State(State),
    .CycleCount(CycleCount), .Done(Done), .Fault(Fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment: instruction memory plus a core that fetches sequentially while enabled.
  logic [15:0] imem [256];
  logic [15:0] shadow [256];
  logic [7:0]  pc;
  logic        mem_init;

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) imem[i] <= 16'h0000;
    end else if (IMemWE) begin
      imem[IMemAddr] <= IMemWData;
    end
  end

  always @(posedge CLK or posedge CpuRST) begin
    if (CpuRST) pc <= 8'h00;
    else if (CpuEN) pc <= pc + 8'd1;
  end

  assign CpuInstMemAddr = pc;
  assign Inst = imem[CpuInstMemAddr];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic [7:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [2:0] st; logic [15:0] cnt; } end_t;
  wr_t  wr_q[$];
  end_t end_q[$];
  wr_t  mon_w;
  end_t mon_e;
  logic done_p, fault_p;

  always @(negedge CLK) begin
    if (!RST) begin
      if (IMemWE) begin
        chk("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", IMemAddr, mon_w.addr);
          chk("wr_data", IMemWData, mon_w.data);
          chk("wr_ready_low", CmdReady, 0);
        end
      end
      if ((Done && !done_p) || (Fault && !fault_p)) begin
        chk("end_expected", 32'(end_q.size() != 0), 1);
        if (end_q.size() != 0) begin
          mon_e = end_q.pop_front();
          chk("end_state", State, mon_e.st);
          chk("end_count", CycleCount, mon_e.cnt);
          chk("end_en_off", CpuEN, 0);
        end
      end
    end
    done_p  <= Done;
    fault_p <= Fault;
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [15:0] d,
                      input bit hold);
    bit ok;
    ok = 1'b0;
    @(negedge CLK);
    CmdValid = 1'b1; CmdOp = op; CmdAddr = a; CmdData = d;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (CmdReady) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    chk("cmd_accepted", 32'(ok), 1);
    if (ok) begin
      if (op == CMD_WRITE) begin
        wr_q.push_back('{addr: a, data: d});
        shadow[a] = d;
      end
      @(posedge CLK);
      #1;
      if (!hold) CmdValid = 1'b0;
    end else begin
      CmdValid = 1'b0;
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      if (State == target) break;
      @(negedge CLK);
    end
    chk(tag, State, target);
  endtask

  time t0, t1;
  int  n_en, bad;

  initial begin
    RST = 1'b1; CmdValid = 1'b0; CmdOp = 2'b00; CmdAddr = 8'h00; CmdData = 16'h0000;
    mem_init = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = 16'h0000;
    repeat (2) @(negedge CLK);
    chk("rst_state", State, ST_IDLE);
    chk("rst_cpurst", CpuRST, 1);
    chk("rst_ready", CmdReady, 0);
    chk("rst_en", CpuEN, 0);
    chk("rst_start", CpuStart, 0);
    chk("rst_we", IMemWE, 0);
    chk("rst_count", CycleCount, 0);
    chk("rst_done", Done, 0);
    chk("rst_fault", Fault, 0);
    mem_init = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_cpurst", CpuRST, 0);
    chk("idle_ready", CmdReady, 1);

    // Back-to-back program load
    send(CMD_WRITE, 8'h00, 16'hB801, 1);
    t0 = $time;
    send(CMD_WRITE, 8'h01, 16'hB902, 1);
    send(CMD_WRITE, 8'h02, 16'h0800, 0);
    t1 = $time;
    chk("wr_throughput", 32'((t1 - t0) / 10), 4);
    @(negedge CLK);
    chk("wr_lat_we", IMemWE, 1);
    chk("wr_lat_state", State, ST_WRITE);
    @(negedge CLK);
    chk("wr_ret_idle", State, ST_IDLE);
    chk("wr_we_drop", IMemWE, 0);

    // RUN to HALT
    end_q.push_back('{st: ST_DONE, cnt: 16'd3});
    send(CMD_RUN, 8'h00, 16'h0000, 0);
    @(negedge CLK);
    chk("run_crst1", CpuRST, 1);
    chk("run_crst1_state", State, ST_CRST);
    chk("run_crst1_en", CpuEN, 0);
    @(negedge CLK);
    chk("run_crst2", CpuRST, 1);
    chk("run_crst2_en", CpuEN, 0);
    @(negedge CLK);
    chk("run_rst_off", CpuRST, 0);
    chk("run_en", CpuEN, 1);
    chk("run_start", CpuStart, 1);
    chk("run_state", State, ST_RUN);
    wait_state(ST_DONE, 20, "halt_reached");
    chk("halt_done", Done, 1);
    chk("halt_en", CpuEN, 0);
    chk("halt_count", CycleCount, 3);

    // NOP program under the watchdog
    send(CMD_WRITE, 8'h00, 16'h0000, 0);
    send(CMD_WRITE, 8'h01, 16'h0000, 0);
    send(CMD_WRITE, 8'h02, 16'h0000, 0);
    @(negedge CLK);
    @(negedge CLK);
    chk("wr_ret_done", State, ST_DONE);
    chk("wr_done_held", Done, 1);
    end_q.push_back('{st: ST_FAULT, cnt: TMO});
    send(CMD_RUN, 8'h00, 16'h0000, 0);
    wait_state(ST_FAULT, 40, "tmo_reached");
    chk("tmo_fault", Fault, 1);
    chk("tmo_en", CpuEN, 0);
    chk("tmo_count", CycleCount, 32'(TMO));
    chk("tmo_done_clr", Done, 0);
    send(CMD_WRITE, 8'h10, 16'h1234, 0);
    @(negedge CLK);
    chk("fault_wr_state", State, ST_WRITE);
    @(negedge CLK);
    chk("fault_wr_ret", State, ST_FAULT);

    // Single-step from reset, step again, resume
    send(CMD_STEP, 8'h00, 16'h0000, 0);
    n_en = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (CpuEN) n_en++;
      if (State == ST_PAUSE) break;
    end
    chk("step_en_cycles", n_en, 1);
    chk("step_pause", State, ST_PAUSE);
    chk("step_count1", CycleCount, 1);
    chk("step_fault_clr", Fault, 0);
    send(CMD_STEP, 8'h00, 16'h0000, 0);
    @(negedge CLK);
    chk("step2_state", State, ST_STEP);
    chk("step2_norst", CpuRST, 0);
    chk("step2_en", CpuEN, 1);
    @(negedge CLK);
    chk("step2_pause", State, ST_PAUSE);
    chk("step_count2", CycleCount, 2);
    end_q.push_back('{st: ST_FAULT, cnt: TMO});
    send(CMD_RUN, 8'h00, 16'h0000, 0);
    @(negedge CLK);
    chk("resume_state", State, ST_RUN);
    chk("resume_norst", CpuRST, 0);
    chk("resume_count", CycleCount, 2);
    wait_state(ST_FAULT, 40, "resume_fault");

    // ABORT mid-run
    send(CMD_RUN, 8'h00, 16'h0000, 0);
    wait_state(ST_RUN, 10, "abort_run_start");
    for (int n = 0; n < 20; n++) begin
      if (CycleCount == 16'd4) break;
      @(negedge CLK);
    end
    chk("abort_cnt4", CycleCount, 4);
    CmdValid = 1'b1; CmdOp = CMD_ABORT;
    #1;
    chk("abort_ready", CmdReady, 1);
    @(posedge CLK);
    #1;
    CmdValid = 1'b0;
    @(negedge CLK);
    chk("abort_state", State, ST_IDLE);
    chk("abort_en", CpuEN, 0);
    chk("abort_start", CpuStart, 0);
    chk("abort_count", CycleCount, 5);
    @(negedge CLK);
    chk("abort_count_held", CycleCount, 5);
    send(CMD_RUN, 8'h00, 16'h0000, 0);
    @(negedge CLK);
    chk("rerun_clr", CycleCount, 0);
    chk("rerun_crst", CpuRST, 1);

    // Asynchronous reset mid-run
    wait_state(ST_RUN, 10, "rst_run_start");
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_state", State, ST_IDLE);
    chk("arst_cpurst", CpuRST, 1);
    chk("arst_en", CpuEN, 0);
    chk("arst_ready", CmdReady, 0);
    chk("arst_count", CycleCount, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    bad = 0;
    for (int i = 0; i < 256; i++) if (imem[i] !== shadow[i]) bad++;
    chk("mem_intact", bad, 0);
    chk("mem_last_wr", imem[8'h10], 16'h1234);

    chk("wr_q_drained", wr_q.size(), 0);
    chk("end_q_drained", end_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcpu_run_ctrl.md
# dcpu_run_ctrl

Host-side run controller for the DCPU core. It loads programs into instruction memory through a valid/ready command port, then sequences the core's RST/EN/Start pins for reset, run, single-step, pause and abort. It detects the HALT opcode on the fetched instruction bus and guards every run with a cycle watchdog. It sits between the host/debug interface, the instruction memory write port, and the DCPU control pins.

## Interface
- TIMEOUT, 16'hFFFF: run-cycle limit; reaching it forces FAULT.
- CLK  in  1  system clock, rising edge. Reset is asynchronous and active-high.
- RST  in  1  asynchronous active-high reset.
- CmdValid  in  1  host command valid.
- CmdReady  out  1  controller accepts the command this edge.
- CmdOp  in  2  00 WRITE, 01 RUN, 10 STEP, 11 ABORT.
- CmdAddr  in  8  instruction memory address (WRITE only).
- CmdData  in  16  instruction word (WRITE only).
- IMemWE  out  1  instruction memory write enable.
- IMemAddr  out  8  instruction memory address: the write address in WRITE, otherwise CpuInstMemAddr.
- IMemWData  out  16  instruction memory write data.
- CpuInstMemAddr  in  8  core fetch address.
- Inst  in  16  instruction currently presented to the core.
- CpuRST, CpuEN, CpuStart  out  1 each  core control pins.
- State  out  3  current state code (debug).
- CycleCount  out  16  core-enabled cycles since the last core reset, saturating.
- Done  out  1  HALT retired.
- Fault  out  1  watchdog expired.

## Operation
- States: IDLE=0, WRITE=1, CRST=2, RUN=3, STEP=4, PAUSE=5, DONE=6, FAULT=7.
- A command is accepted on a rising edge when CmdValid and CmdReady are both 1.
- CmdReady is 1 in IDLE, PAUSE, DONE and FAULT.
- In RUN, STEP and CRST, CmdReady is 1 only when CmdOp=ABORT. Other commands stall.
- CmdReady is 0 in WRITE.
- WRITE (from IDLE/PAUSE/DONE/FAULT):
  - Latch CmdAddr and CmdData.
  - Spend one cycle in WRITE with IMemWE=1, then return to the originating state.
- RUN:
  - From IDLE/DONE/FAULT, go to CRST: CpuRST=1 for exactly 2 cycles, CycleCount, Done and Fault cleared. Then go to RUN.
  - From PAUSE, go directly to RUN with no reset.
- STEP: same entry paths as RUN, but enters STEP instead. STEP holds CpuEN=1 for exactly one cycle, then goes to PAUSE.
- RUN and STEP drive CpuEN=1 and CpuStart=1. All other states drive both 0.
- Halt detection: in RUN or STEP, if Inst[15:11]==5'b00001, go to DONE on the next edge. Done=1 until the next CRST. HALT detection in STEP takes priority over PAUSE.
- Watchdog: CycleCount increments on each CpuEN=1 edge and saturates at 16'hFFFF. If CycleCount==TIMEOUT in RUN, go to FAULT with Fault=1. HALT on the same cycle wins (DONE).
- ABORT, from any state except WRITE: go to IDLE next edge. CpuEN drops immediately. CycleCount and Done/Fault are held.

## Timing
- Reset values:
  - State=IDLE.
  - IMemWE=0, CpuEN=0, CpuStart=0.
  - CycleCount=0, Done=0, Fault=0.
  - CpuRST=1 while RST is high; CpuRST = RST | (State==CRST).
  - CmdReady=0 while RST is high.
- Outputs are registered from State, except CmdReady, CpuRST and IMemAddr, which are combinational.
- WRITE latency: accept at edge N, IMemWE high during cycle N+1. Sustained write throughput is one word per 2 cycles.
- RUN from IDLE: accept at N, CpuRST high during N+1 and N+2, CpuEN high from N+3.
- HALT visible in cycle M: CpuEN=0 and Done=1 from M+1.
- RST asserted mid-run: all outputs take reset values immediately; memory contents are untouched.

## Structure
- Shared package dcpu_pkg holds:
  - Opcode constants (OP_HALT=5'b00001, full 5-bit ISA list).
  - Command encodings CMD_WRITE/RUN/STEP/ABORT.
  - State encoding.
- One sub-module, dcpu_cycle_counter: 16-bit saturating counter with clear, enable and a compare-equal output against TIMEOUT.

## Test plan
- WRITE 0x0000→B801, 0x0001→B902, 0x0002→0800, back-to-back CmdValid → IMemWE pulses at each address, CmdReady low between writes, State returns to IDLE.
- RUN the program above → CpuRST high for 2 cycles, then CpuEN high. Fetch of 0x0800 (HALT) → Done=1, CpuEN=0 next cycle, CycleCount=3.
- TIMEOUT=8, program of NOPs only → Fault=1 at CycleCount=8, CpuEN=0, State=FAULT. A subsequent WRITE is accepted.
- STEP from IDLE → one CpuEN cycle then PAUSE, CycleCount=1. STEP again → CycleCount=2. RUN → resumes with no CpuRST pulse.
- ABORT during RUN after 5 cycles → State=IDLE next edge, CpuEN=0, CycleCount=5 held. A new RUN clears CycleCount to 0.
- RST asserted mid-RUN → CpuRST=1, CpuEN=0, State=IDLE immediately (asynchronous). After release, the memory image still matches the last writes.
